coeff_ram_loader: RTL

Writable twiddle-coefficient store for the radix-2 FFT stages: accepts a block of packed complex coefficients over a valid/ready stream, writes them into an internal SIZE-entry RAM, then replays them cyclically to the butterfly datapath while `run` is high. It is the write-side counterpart of the fixed coefficient ROMs. Coefficient tables can then be reloaded at run time, for example when N or direction changes, without re-synthesis. Output word format matches the ROM streams, so the block drops into any stage's coefficient input.

---
 rtl/fft_coeff_pkg.sv | 22 ++
 rtl/coeff_ram_loader_if.sv | 32 +++
 rtl/coeff_dpram.sv | 36 +++
 rtl/coeff_ram_loader.sv | 93 +++++++++
 4 files changed

// File: rtl/fft_coeff_pkg.sv
// rtl/fft_coeff_pkg.sv - shared widths, coefficient word type and loader states
package fft_coeff_pkg;

    // Bits per real/imaginary component, Q1.(CW-1) two's complement
    localparam int CW           = 11;
    // Default number of entries in one coefficient table
    localparam int DEFAULT_SIZE = 32;

    // Packed complex coefficient, real part in the upper half
    typedef struct packed {
        logic signed [CW-1:0] re;
        logic signed [CW-1:0] im;
    } coeff_t;

    // Loader control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } load_state_t;

endpackage

// File: rtl/coeff_ram_loader_if.sv
// rtl/coeff_ram_loader_if.sv - load stream, control and coefficient output bundle
interface coeff_ram_loader_if
    import fft_coeff_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
);
    localparam int AW = $clog2(SIZE);

    logic          load_start;
    logic          in_valid;
    coeff_t        in_data;
    logic          in_ready;
    logic          load_done;
    logic          loaded;
    logic          run;
    coeff_t        coeff_out;
    logic          coeff_valid;
    logic [AW-1:0] coeff_idx;

    // Producer of coefficient tables and consumer of the replayed stream
    modport master (
        output load_start, in_valid, in_data, run,
        input  in_ready, load_done, loaded, coeff_out, coeff_valid, coeff_idx
    );

    // The coefficient store itself
    modport slave (
        input  load_start, in_valid, in_data, run,
        output in_ready, load_done, loaded, coeff_out, coeff_valid, coeff_idx
    );

endinterface

// File: rtl/coeff_dpram.sv
// rtl/coeff_dpram.sv - one write port, one registered read port coefficient RAM
module coeff_dpram
    import fft_coeff_pkg::*;
#(
    parameter  int SIZE = DEFAULT_SIZE,
    localparam int AW   = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  coeff_t        wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output coeff_t        rd_data
);

    coeff_t mem [SIZE];

    // Array write; contents are deliberately left unreset so the array maps to block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; the output register alone is cleared and holds while rd_en is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/coeff_ram_loader.sv
// rtl/coeff_ram_loader.sv - reloadable twiddle store replayed cyclically to a butterfly stage
module coeff_ram_loader
    import fft_coeff_pkg::*;
#(
    parameter  int SIZE = DEFAULT_SIZE,
    localparam int AW   = $clog2(SIZE)
) (
    input  logic                clk,
    input  logic                rst_n,
    coeff_ram_loader_if.slave   bus
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(SIZE - 1);

    load_state_t   state;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_idx;
    logic          beat;
    logic          rd_en;

    // A restart request blocks the beat offered in the same cycle
    assign bus.in_ready = (state == ST_LOAD) && !bus.load_start;
    assign beat         = bus.in_valid && bus.in_ready;

    // The RAM output register doubles as coeff_out, so a read issued at an edge is visible right after it
    assign rd_en        = (state == ST_READY) && bus.run && !bus.load_start;

    coeff_dpram #(
        .SIZE (SIZE)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (beat),
        .wr_addr (wr_addr),
        .wr_data (bus.in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_idx),
        .rd_data (bus.coeff_out)
    );

    // Load/replay sequencer with address counters and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            wr_addr         <= '0;
            rd_idx          <= '0;
            bus.coeff_valid <= 1'b0;
            bus.coeff_idx   <= '0;
            bus.load_done   <= 1'b0;
            bus.loaded      <= 1'b0;
        end else begin
            bus.load_done <= 1'b0;
            if (bus.load_start) begin
                state           <= ST_LOAD;
                wr_addr         <= '0;
                rd_idx          <= '0;
                bus.loaded      <= 1'b0;
                bus.coeff_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        bus.coeff_valid <= 1'b0;
                    end
                    ST_LOAD: begin
                        bus.coeff_valid <= 1'b0;
                        if (beat) begin
                            // SIZE is a power of two, so the counter wraps back to 0 by itself
                            wr_addr <= wr_addr + AW'(1);
                            if (wr_addr == LAST_ADDR) begin
                                state         <= ST_READY;
                                bus.load_done <= 1'b1;
                                bus.loaded    <= 1'b1;
                                rd_idx        <= '0;
                            end
                        end
                    end
                    ST_READY: begin
                        bus.coeff_valid <= bus.run;
                        if (bus.run) begin
                            bus.coeff_idx <= rd_idx;
                            rd_idx        <= rd_idx + AW'(1);
                        end
                    end
                    default: begin
                        state           <= ST_IDLE;
                        bus.coeff_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
